// File: rtl/ps_din_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps_din_pkg
// Purpose : Shared constants and helpers for the ps_din_edge_capture block.
// Revision: 1.0 - initial release
// ============================================================================
package ps_din_pkg;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RSVD     = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_EVT_CNT  = 3'd4;

    // Width of a counter that must reach max_count; at least one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps_din_debounce.sv
`default_nettype none
// ============================================================================
// Module  : ps_din_debounce
// Purpose : One input channel: 2-flop synchroniser plus persistence filter.
// Revision: 1.0 - initial release
// ============================================================================
module ps_din_debounce
    import ps_din_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    localparam int                 c_cnt_w   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic               r_d1;
    logic               r_d2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    // The counter tracks how long the synchronised input has disagreed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d1     <= 1'b0;
            r_d2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_d1 <= din;
            r_d2 <= r_d1;
            if (r_d2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable <= r_d2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/ps_din_edge_capture.sv
`default_nettype none
// ============================================================================
// Module  : ps_din_edge_capture
// Purpose : Debounced multi-channel input PIO with W1C edge capture and IRQ.
//           Define PS_DIN_EVENT_COUNT_EN to add the event counter at address 4.
// Revision: 1.0 - initial release
// ============================================================================
module ps_din_edge_capture
    import ps_din_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_detect;
    logic [WIDTH-1:0] w_cap_clr;
    logic [WIDTH-1:0] r_stable_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rd_mux;
    logic [31:0]      w_evt_cnt;
    logic             w_wr;
    logic             w_unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        ps_din_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .din    (in_port[i]),
            .stable (w_stable[i])
        );
    end

    if (EDGE_TYPE == EDGE_RISING) begin : g_rise
        assign w_detect = w_stable & ~r_stable_prev;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
        assign w_detect = ~w_stable & r_stable_prev;
    end else begin : g_any
        assign w_detect = w_stable ^ r_stable_prev;
    end

    assign w_wr      = chipselect & ~write_n;
    assign w_cap_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? writedata[WIDTH-1:0] : '0;

    // Detection is OR-ed in after the clear so a coincident edge is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_prev <= '0;
            r_irq_mask    <= '0;
            r_edge_cap    <= '0;
            r_readdata    <= '0;
        end else begin
            r_stable_prev <= w_stable;
            if (w_wr && (address == ADDR_IRQ_MASK)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_detect;
            r_readdata <= w_rd_mux;
        end
    end

`ifdef PS_DIN_EVENT_COUNT_EN
    logic [31:0] r_event_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_count <= '0;
        end else if (w_wr && (address == ADDR_EVT_CNT)) begin
            r_event_count <= '0;
        end else if ((|w_detect) && (r_event_count != 32'hFFFF_FFFF)) begin
            r_event_count <= r_event_count + 32'd1;
        end
    end

    assign w_evt_cnt = r_event_count;
`else
    assign w_evt_cnt = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux = 32'(w_stable);
            ADDR_IRQ_MASK: w_rd_mux = 32'(r_irq_mask);
            ADDR_EDGE_CAP: w_rd_mux = 32'(r_edge_cap);
            ADDR_EVT_CNT:  w_rd_mux = w_evt_cnt;
            default:       w_rd_mux = '0;
        endcase
    end

    // Upper write-data bits have no destination at narrow widths.
    assign w_unused_wdata = ^writedata;

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_ps_din_edge_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps_din_edge_capture
// Purpose : Self-checking bench: rising/falling/any instances against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps_din_edge_capture;

    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd [3];
    logic          irq_v [3];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    // index 0 = rising, 1 = falling, 2 = any
    ps_din_edge_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
        .in_port(in_port), .irq(irq_v[0]));
    ps_din_edge_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
        .in_port(in_port), .irq(irq_v[1]));
    ps_din_edge_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
        .in_port(in_port), .irq(irq_v[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] s_hist [$];   // in_port seen at each edge
    bit           r_hist [$];   // reset seen at each edge
    logic [W-1:0] u_hist [$];   // synchronised value used by the filter at each edge
    logic [W-1:0] m_stable = '0, m_prev = '0, m_mask = '0;
    logic [W-1:0] m_cap [3] = '{default: '0};
    logic [31:0]  m_evt [3] = '{default: '0};
    logic [31:0]  m_rd  [3] = '{default: '0};

    function automatic logic [31:0] model_rd(input int t, input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_stable};
            3'd2: return {24'h0, m_mask};
            3'd3: return {24'h0, m_cap[t]};
`ifdef PS_DIN_EVENT_COUNT_EN
            3'd4: return m_evt[t];
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : p_model
        int           n;
        int           idx;
        bit           flip;
        bit           wr;
        logic [W-1:0] u, nst, clr;
        logic [W-1:0] det [3];
        s_hist.push_back(in_port);
        r_hist.push_back(reset);
        n = s_hist.size() - 1;
        if (reset) begin
            u_hist.push_back('0);
            m_stable = '0; m_prev = '0; m_mask = '0;
            for (int t = 0; t < 3; t++) begin
                m_cap[t] = '0; m_evt[t] = '0; m_rd[t] = '0;
            end
        end else begin
            for (int t = 0; t < 3; t++) m_rd[t] = model_rd(t, address);
            // Input reaches the filter two edges later unless reset intervened.
            u = (n >= 2 && !r_hist[n-1] && !r_hist[n-2]) ? s_hist[n-2] : '0;
            u_hist.push_back(u);
            // A channel changes once D+1 consecutive post-reset samples oppose it.
            nst = m_stable;
            for (int b = 0; b < W; b++) begin
                flip = 1'b1;
                for (int j = 0; j <= D; j++) begin
                    idx = n - j;
                    if (idx < 0) flip = 1'b0;
                    else if (r_hist[idx] || u_hist[idx][b] == m_stable[b]) flip = 1'b0;
                end
                if (flip) nst[b] = ~m_stable[b];
            end
            det[0] = m_stable & ~m_prev;
            det[1] = ~m_stable & m_prev;
            det[2] = m_stable ^ m_prev;
            wr  = chipselect && !write_n;
            clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
            for (int t = 0; t < 3; t++) begin
                m_cap[t] = (m_cap[t] & ~clr) | det[t];
                if (wr && address == 3'd4) m_evt[t] = 32'h0;
                else if (|det[t] && m_evt[t] != 32'hFFFF_FFFF) m_evt[t] = m_evt[t] + 1;
            end
            if (wr && address == 3'd2) m_mask = writedata[W-1:0];
            m_prev   = m_stable;
            m_stable = nst;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int t = 0; t < 3; t++) begin
                check_eq($sformatf("rd_t%0d", t), rd[t], m_rd[t]);
                check_eq($sformatf("irq_t%0d", t), {31'b0, irq_v[t]}, {31'b0, |(m_cap[t] & m_mask)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_port = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            @(negedge clk);
            check_eq($sformatf("reset_rd_a%0d", a), rd[2], 32'h0);
            check_eq("reset_irq", {31'b0, irq_v[2]}, 32'h0);
        end

        // Rise on bit 3: stable flips at k+6, visible on readdata at k+7.
        address = 3'd0;
        repeat (4) @(negedge clk);
        in_port[3] = 1'b1;
        repeat (7) @(negedge clk);
        check_eq("lat_k6_bit3", {31'b0, rd[2][3]}, 32'h0);
        @(negedge clk);
        check_eq("lat_k7_bit3", {31'b0, rd[2][3]}, 32'h1);
        address = 3'd3;
        @(negedge clk);
        check_eq("cap_any_bit3", rd[2], 32'h08);
        check_eq("cap_rise_bit3", rd[0], 32'h08);
        check_eq("cap_fall_bit3", rd[1], 32'h00);

        // Glitches: 4 cycles rejected, 5 cycles accepted.
        in_port[0] = 1'b1;
        repeat (4) @(negedge clk);
        in_port[0] = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("glitch4_cap", rd[2], 32'h08);
        address = 3'd0;
        @(negedge clk);
        check_eq("glitch4_data", rd[2], 32'h08);
        in_port[0] = 1'b1;
        repeat (5) @(negedge clk);
        in_port[0] = 1'b0;
        repeat (15) @(negedge clk);
        address = 3'd3;
        @(negedge clk);
        check_eq("pulse5_cap_any", rd[2], 32'h09);
        check_eq("pulse5_cap_rise", rd[0], 32'h09);
        check_eq("pulse5_cap_fall", rd[1], 32'h01);

        // Mask / W1C / set-wins-over-clear.
        bus_write(3'd2, 32'h08);
        check_eq("irq_masked_on", {31'b0, irq_v[2]}, 32'h1);
        bus_write(3'd3, 32'h08);
        check_eq("irq_after_clr", {31'b0, irq_v[2]}, 32'h0);
        address = 3'd3;
        @(negedge clk);
        check_eq("cap_after_clr", rd[2], 32'h01);
        in_port[0] = 1'b1;
        repeat (7) @(negedge clk);
        bus_write(3'd3, 32'h01);
        address = 3'd3;
        @(negedge clk);
        check_eq("set_wins_any", rd[2], 32'h01);
        check_eq("set_wins_rise", rd[0], 32'h01);
        check_eq("clr_no_edge_fall", rd[1], 32'h00);

        // Event counter: rise, fall, rise on bit 7.
        bus_write(3'd4, 32'h0);
        in_port[7] = 1'b1;
        repeat (12) @(negedge clk);
        in_port[7] = 1'b0;
        repeat (12) @(negedge clk);
        in_port[7] = 1'b1;
        repeat (12) @(negedge clk);
        address = 3'd4;
        @(negedge clk);
`ifdef PS_DIN_EVENT_COUNT_EN
        check_eq("evt_any", rd[2], 32'd3);
        check_eq("evt_rise", rd[0], 32'd2);
        check_eq("evt_fall", rd[1], 32'd1);
        bus_write(3'd4, 32'h0);
        address = 3'd4;
        @(negedge clk);
        check_eq("evt_cleared", rd[2], 32'd0);
`else
        check_eq("evt_absent_any", rd[2], 32'd0);
        check_eq("evt_absent_rise", rd[0], 32'd0);
`endif

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, (b < 4) ? 4 : 14) == 0) in_port[b] = ~in_port[b];
            end
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
